// File: rtl/lcd_seq_ctrl_pkg.sv
// lcd_seq_ctrl shared types: FSM state encoding and mode constants.
// Also a width helper for the optional timeout counter.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic MODE_REFRESH = 1'b0;
  localparam logic MODE_INIT    = 1'b1;

  function automatic int cnt_w(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/lcd_seq_ctrl_if.sv
// lcd_seq_ctrl control/handshake bundle.
// master = sequencer, slave = host side plus byte writer.
interface lcd_seq_ctrl_if #(
  parameter int SEL_W = 4,
  parameter int GAP_W = 8
);

  logic             lcd_enable;
  logic             mode;
  logic [SEL_W-1:0] lcd_cnt;
  logic [GAP_W-1:0] gap_cycles;
  logic             abort;
  logic             wr_enable;
  logic             wr_finish;
  logic [SEL_W-1:0] mux_sel;
  logic [SEL_W-1:0] init_sel;
  logic             lcd_finish;
  logic             busy;
  logic             seq_err;

  modport master (
    input  lcd_enable,
    input  mode,
    input  lcd_cnt,
    input  gap_cycles,
    input  abort,
    input  wr_finish,
    output wr_enable,
    output mux_sel,
    output init_sel,
    output lcd_finish,
    output busy,
    output seq_err
  );

  modport slave (
    output lcd_enable,
    output mode,
    output lcd_cnt,
    output gap_cycles,
    output abort,
    output wr_finish,
    input  wr_enable,
    input  mux_sel,
    input  init_sel,
    input  lcd_finish,
    input  busy,
    input  seq_err
  );

endinterface

// File: rtl/lcd_seq_gap_cnt.sv
// Loadable down-counter with zero flag.
// Saturates at zero; load wins over decrement.
module lcd_seq_gap_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  assign zero = (count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/lcd_seq_ctrl.sv
// LCD command-sequence controller: walks idx down to 0, one write per idx.
// Optional wr_finish timeout enabled by defining LCD_SEQ_TIMEOUT_EN.
import lcd_pkg::*;

module lcd_seq_ctrl #(
  parameter int SEL_W      = 4,
  parameter int GAP_W      = 8,
  parameter int TMO_CYCLES = 1000
) (
  input logic           clk,
  input logic           rst,
  lcd_seq_ctrl_if.master bus
);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             mode_q, mode_d;
  logic [SEL_W-1:0] mux_q, init_q;
  logic             gap_load, gap_dec, gap_zero;
  logic             start;

`ifdef LCD_SEQ_TIMEOUT_EN
  localparam int TW = cnt_w(TMO_CYCLES);
  logic tmo_load, tmo_dec, tmo_zero, tmo_hit;
  logic err_q;
`endif

  lcd_seq_gap_cnt #(.W(GAP_W)) u_gap (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (gap_q - GAP_W'(1)),
    .dec      (gap_dec),
    .zero     (gap_zero)
  );

`ifdef LCD_SEQ_TIMEOUT_EN
  lcd_seq_gap_cnt #(.W(TW)) u_tmo (
    .clk      (clk),
    .rst      (rst),
    .load     (tmo_load),
    .load_val (TW'(TMO_CYCLES - 1)),
    .dec      (tmo_dec),
    .zero     (tmo_zero)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
      mode_q  <= MODE_REFRESH;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    gap_d    = gap_q;
    mode_d   = mode_q;
    gap_load = 1'b0;
    gap_dec  = 1'b0;
    start    = 1'b0;
`ifdef LCD_SEQ_TIMEOUT_EN
    tmo_load = 1'b0;
    tmo_dec  = 1'b0;
    tmo_hit  = 1'b0;
`endif
    if (state_q != IDLE && bus.abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.lcd_enable) begin
            start   = 1'b1;
            state_d = ISSUE;
            mode_d  = bus.mode;
            idx_d   = bus.lcd_cnt;
            gap_d   = bus.gap_cycles;
          end
        end
        ISSUE: begin
          state_d = WAIT;
`ifdef LCD_SEQ_TIMEOUT_EN
          tmo_load = 1'b1;
`endif
        end
        WAIT: begin
          if (bus.wr_finish) begin
            if (idx_q == '0) begin
              state_d = DONE;
            end else if (gap_q == '0) begin
              idx_d   = idx_q - SEL_W'(1);
              state_d = ISSUE;
            end else begin
              gap_load = 1'b1;
              state_d  = GAP;
            end
          end else begin
`ifdef LCD_SEQ_TIMEOUT_EN
            tmo_dec = 1'b1;
            if (tmo_zero) begin
              tmo_hit = 1'b1;
              state_d = IDLE;
            end
`endif
          end
        end
        GAP: begin
          // counter was loaded with gap-1, so zero marks the last gap cycle
          if (gap_zero) begin
            idx_d   = idx_q - SEL_W'(1);
            state_d = ISSUE;
          end else begin
            gap_dec = 1'b1;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // only the mux picked by the active mode tracks idx
  always_ff @(posedge clk) begin
    if (rst) begin
      mux_q  <= '0;
      init_q <= '0;
    end else if (mode_d == MODE_REFRESH) begin
      mux_q  <= idx_d;
    end else begin
      init_q <= idx_d;
    end
  end

`ifdef LCD_SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (start) begin
      err_q <= 1'b0;
    end else if (tmo_hit) begin
      err_q <= 1'b1;
    end
  end

  assign bus.seq_err = err_q;
`else
  assign bus.seq_err = 1'b0;
`endif

  assign bus.wr_enable  = (state_q == ISSUE);
  assign bus.lcd_finish = (state_q == DONE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.mux_sel    = mux_q;
  assign bus.init_sel   = init_q;

endmodule
